// File: rtl/cla_pipe_addsub_pkg.sv
// Shared constants and helpers for the pipelined CLA adder/subtractor.
// Default operand split is 32 bits resolved 8 bits per stage.
// seg_count gives the number of segment stages, which is also the latency.
package cla_pipe_addsub_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_SEG_WIDTH = 8;

    // Number of segment stages for a given operand split.
    function automatic int seg_count(input int width, input int seg_width);
        return width / seg_width;
    endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_WIDTH-bit carry-lookahead adder slice.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline stage decides when to capture.
module cla_segment
    import cla_pipe_addsub_pkg::*;
#(
    parameter int SEG_WIDTH = DEFAULT_SEG_WIDTH
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] sum,
    output logic                 cout
);

    logic [SEG_WIDTH-1:0] gen;
    logic [SEG_WIDTH-1:0] prop;
    logic [SEG_WIDTH:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Flattened lookahead: each carry is built directly from generate/propagate
    // terms and cin, so no carry ripples through a previous carry bit.
    always_comb begin : p_lookahead
        logic acc;
        logic run;
        acc   = 1'b0;
        run   = 1'b0;
        carry = '0;
        carry[0] = cin;
        for (int i = 0; i < SEG_WIDTH; i++) begin
            acc = gen[i];
            run = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (run & gen[j]);
                run = run & prop[j];
            end
            carry[i+1] = acc | (run & cin);
        end
    end

    assign sum  = prop ^ carry[SEG_WIDTH-1:0];
    assign cout = carry[SEG_WIDTH];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/subtract resolving one CLA segment per stage, carry forwarded stage to stage.
// Latency: NSEG = WIDTH/SEG_WIDTH cycles from input accept to output valid; 1 beat/cycle.
// Backpressure: global stall; when out_valid && !out_ready every stage holds and in_ready=0.
module cla_pipe_addsub
    import cla_pipe_addsub_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int SEG_WIDTH = DEFAULT_SEG_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NSEG = seg_count(WIDTH, SEG_WIDTH);
    localparam int MSB  = WIDTH - 1;

    if ((SEG_WIDTH < 1) || ((WIDTH % SEG_WIDTH) != 0)) begin : g_bad_split
        $error("cla_pipe_addsub: WIDTH (%0d) must be a multiple of SEG_WIDTH (%0d)", WIDTH, SEG_WIDTH);
    end

    // Stage 0 holds prepared operands; stage k holds k resolved segments.
    // Operand copies are only needed up to the stage feeding the last segment.
    logic             advance;
    logic             stg_vld [0:NSEG];
    logic             stg_cry [0:NSEG];
    logic [WIDTH-1:0] stg_a   [0:NSEG-1];
    logic [WIDTH-1:0] stg_b   [0:NSEG-1];
    logic [WIDTH-1:0] stg_sum [1:NSEG];
    logic             ovf_q;

    assign advance   = !stg_vld[NSEG] || out_ready;
    assign in_ready  = advance;
    assign out_valid = stg_vld[NSEG];
    assign out_sum   = stg_sum[NSEG];
    assign out_cout  = stg_cry[NSEG];
    assign out_ovf   = ovf_q;

    // Capture: subtract folds into inverted B and inverted carry-in.
    always_ff @(posedge clock) begin
        if (reset) begin
            stg_vld[0] <= 1'b0;
        end else if (advance) begin
            stg_vld[0] <= in_valid;
            if (in_valid) begin
                stg_a[0]   <= in_a;
                stg_b[0]   <= in_b ^ {WIDTH{in_sub}};
                stg_cry[0] <= in_cin ^ in_sub;
            end
        end
    end

    for (genvar k = 1; k <= NSEG; k++) begin : g_stage
        localparam int LO = (k - 1) * SEG_WIDTH;

        logic [SEG_WIDTH-1:0] seg_sum;
        logic                 seg_cout;
        logic [WIDTH-1:0]     sum_prev;
        logic [WIDTH-1:0]     sum_nxt;

        cla_segment #(
            .SEG_WIDTH(SEG_WIDTH)
        ) u_seg (
            .a   (stg_a[k-1][LO +: SEG_WIDTH]),
            .b   (stg_b[k-1][LO +: SEG_WIDTH]),
            .cin (stg_cry[k-1]),
            .sum (seg_sum),
            .cout(seg_cout)
        );

        if (k == 1) begin : g_first
            assign sum_prev = '0;
        end else begin : g_rest
            assign sum_prev = stg_sum[k-1];
        end

        // Merge this segment's sum bits over the bits already resolved below it.
        always_comb begin
            sum_nxt = sum_prev;
            sum_nxt[LO +: SEG_WIDTH] = seg_sum;
        end

        // Resolved sum and carry advance with the beat; the output stage resets to zero
        // and otherwise keeps its last result across bubbles.
        always_ff @(posedge clock) begin
            if (reset) begin
                stg_vld[k] <= 1'b0;
                if (k == NSEG) begin
                    stg_sum[k] <= '0;
                    stg_cry[k] <= 1'b0;
                end
            end else if (advance) begin
                stg_vld[k] <= stg_vld[k-1];
                if (stg_vld[k-1]) begin
                    stg_sum[k] <= sum_nxt;
                    stg_cry[k] <= seg_cout;
                end
            end
        end

        if (k < NSEG) begin : g_skew
            // Skew buffer: operands ride along so later stages see the unresolved upper bits.
            always_ff @(posedge clock) begin
                if (advance && stg_vld[k-1]) begin
                    stg_a[k] <= stg_a[k-1];
                    stg_b[k] <= stg_b[k-1];
                end
            end
        end else begin : g_out
            // Signed overflow: operands agree in sign but the result sign differs.
            always_ff @(posedge clock) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (advance && stg_vld[k-1]) begin
                    ovf_q <= (stg_a[k-1][MSB] == stg_b[k-1][MSB]) &&
                             (sum_nxt[MSB] != stg_a[k-1][MSB]);
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub: default 32/8 instance plus 64/16, 8/8, 48/4.
// Directed vectors with hand-computed results; streaming scenarios use an arithmetic model.
// Inputs driven on the falling edge, outputs sampled shortly after it.
module tb_cla_pipe_addsub;

    logic        clock;
    logic        reset;
    logic        in_valid, in_ready, in_sub, in_cin;
    logic [31:0] in_a, in_b, out_sum;
    logic        out_valid, out_ready, out_cout, out_ovf;

    logic        v64, r64, s64, c64, ov64, or64, co64, of64;
    logic [63:0] a64, b64, sum64;
    logic        v8, r8, s8, c8, ov8, or8, co8, of8;
    logic [7:0]  a8, b8, sum8;
    logic        v48, r48, s48, c48, ov48, or48, co48, of48;
    logic [47:0] a48, b48, sum48;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    cla_pipe_addsub dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf)
    );

    cla_pipe_addsub #(.WIDTH(64), .SEG_WIDTH(16)) dut64 (
        .clock(clock), .reset(reset),
        .in_valid(v64), .in_ready(r64), .in_a(a64), .in_b(b64), .in_sub(s64), .in_cin(c64),
        .out_valid(ov64), .out_ready(or64), .out_sum(sum64), .out_cout(co64), .out_ovf(of64)
    );

    cla_pipe_addsub #(.WIDTH(8), .SEG_WIDTH(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8), .in_sub(s8), .in_cin(c8),
        .out_valid(ov8), .out_ready(or8), .out_sum(sum8), .out_cout(co8), .out_ovf(of8)
    );

    cla_pipe_addsub #(.WIDTH(48), .SEG_WIDTH(4)) dut48 (
        .clock(clock), .reset(reset),
        .in_valid(v48), .in_ready(r48), .in_a(a48), .in_b(b48), .in_sub(s48), .in_cin(c48),
        .out_valid(ov48), .out_ready(or48), .out_sum(sum48), .out_cout(co48), .out_ovf(of48)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Arithmetic reference: signed range test for overflow, unsigned compare for carry/borrow.
    function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sub, input logic cin);
        logic signed [33:0] sa, sb, w;
        logic [33:0]        ua, ub, uw;
        logic               cout, ovf;
        sa = {{2{a[31]}}, a};
        sb = {{2{b[31]}}, b};
        ua = {2'b00, a};
        ub = {2'b00, b};
        uw = '0;
        if (sub) begin
            w    = sa - sb - {33'd0, cin};
            cout = (ua >= (ub + {33'd0, cin}));
        end else begin
            w    = sa + sb + {33'd0, cin};
            uw   = ua + ub + {33'd0, cin};
            cout = uw[32];
        end
        ovf = (w > 34'sd2147483647) || (w < -34'sd2147483648);
        return {ovf, cout, w[31:0]};
    endfunction

    // Drive one beat into the idle main DUT and return cycles until out_valid (-1 on timeout).
    task automatic send_main(input logic [31:0] a, input logic [31:0] b,
                             input logic sub, input logic cin, output int lat);
        @(negedge clock);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_cin = cin;
        lat = -1;
        for (int n = 1; n < 40; n++) begin
            @(negedge clock);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    // Same for one of the sweep instances: 0 = 64/16, 1 = 8/8, 2 = 48/4.
    task automatic send_sweep(input int which, input logic [63:0] a, input logic [63:0] b,
                              input logic sub, input logic cin, output int lat);
        logic ov;
        @(negedge clock);
        case (which)
            0:       begin v64 = 1'b1; a64 = a;        b64 = b;        s64 = sub; c64 = cin; end
            1:       begin v8  = 1'b1; a8  = a[7:0];   b8  = b[7:0];   s8  = sub; c8  = cin; end
            default: begin v48 = 1'b1; a48 = a[47:0];  b48 = b[47:0];  s48 = sub; c48 = cin; end
        endcase
        lat = -1;
        for (int n = 1; n < 40; n++) begin
            @(negedge clock);
            v64 = 1'b0; v8 = 1'b0; v48 = 1'b0;
            ov = (which == 0) ? ov64 : ((which == 1) ? ov8 : ov48);
            if (ov) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (out_sum !== 32'h0) $display("FAIL reset_out_sum: got %h expected 00000000", out_sum); else passes++;
        checks++; if (out_cout !== 1'b0) $display("FAIL reset_out_cout: got %b expected 0", out_cout); else passes++;
        checks++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
    endtask

    task automatic test_add();
        vec_t v[4];
        int   lat;
        v[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        v[1] = '{32'h00000010, 32'h00000020, 1'b0, 1'b1, 32'h00000031, 1'b0, 1'b0};
        v[2] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        v[3] = '{32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_main(v[i].a, v[i].b, v[i].sub, v[i].cin, lat);
            checks++; if (lat != 4) $display("FAIL add%0d_latency: got %0d expected 4", i, lat); else passes++;
            checks++; if (out_sum !== v[i].sum) $display("FAIL add%0d_sum: got %h expected %h", i, out_sum, v[i].sum); else passes++;
            checks++; if (out_cout !== v[i].cout) $display("FAIL add%0d_cout: got %b expected %b", i, out_cout, v[i].cout); else passes++;
            checks++; if (out_ovf !== v[i].ovf) $display("FAIL add%0d_ovf: got %b expected %b", i, out_ovf, v[i].ovf); else passes++;
        end
    endtask

    task automatic test_sub();
        vec_t v[4];
        int   lat;
        v[0] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        v[1] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
        v[2] = '{32'h00000010, 32'h00000003, 1'b1, 1'b1, 32'h0000000C, 1'b1, 1'b0};
        v[3] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_main(v[i].a, v[i].b, v[i].sub, v[i].cin, lat);
            checks++; if (lat != 4) $display("FAIL sub%0d_latency: got %0d expected 4", i, lat); else passes++;
            checks++; if (out_sum !== v[i].sum) $display("FAIL sub%0d_sum: got %h expected %h", i, out_sum, v[i].sum); else passes++;
            checks++; if (out_cout !== v[i].cout) $display("FAIL sub%0d_cout: got %b expected %b", i, out_cout, v[i].cout); else passes++;
            checks++; if (out_ovf !== v[i].ovf) $display("FAIL sub%0d_ovf: got %b expected %b", i, out_ovf, v[i].ovf); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] expq[$];
        logic [33:0] exp_r;
        int sent, got;
        sent = 0; got = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
            @(negedge clock);
            if (sent < 16) begin
                in_valid = 1'b1;
                in_a     = 32'h9E3779B9 * 32'(sent + 1);
                in_b     = 32'h7F4A7C15 ^ (32'(sent) * 32'h01000193);
                in_sub   = sent[0];
                in_cin   = sent[2];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (sent < 16) begin
                checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b expected 1 at cycle %0d", in_ready, cyc); else passes++;
            end
            if (got > 0) begin
                checks++; if (out_valid !== 1'b1) $display("FAIL b2b_gap: out_valid got %b expected 1 at cycle %0d", out_valid, cyc); else passes++;
            end
            if (out_valid) begin
                exp_r = (expq.size() > 0) ? expq.pop_front() : 34'h3FFFFFFFF;
                checks++;
                if ({out_ovf, out_cout, out_sum} !== exp_r)
                    $display("FAIL b2b_result%0d: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                             got, out_ovf, out_cout, out_sum, exp_r[33], exp_r[32], exp_r[31:0]);
                else passes++;
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_model(in_a, in_b, in_sub, in_cin));
                sent++;
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 16) $display("FAIL b2b_count: got %0d results expected 16", got); else passes++;
    endtask

    task automatic test_backpressure();
        logic [33:0] expq[$];
        logic [33:0] exp_r, held;
        bit held_set;
        int sent, got;
        sent = 0; got = 0; held_set = 1'b0; held = '0;
        for (int cyc = 0; cyc < 80 && got < 12; cyc++) begin
            @(negedge clock);
            out_ready = !((cyc >= 4) && (cyc < 10));
            if (sent < 12) begin
                in_valid = 1'b1;
                in_a     = 32'h0F1E2D3C + 32'(sent) * 32'h01010101;
                in_b     = 32'hF0E1D2C3 ^ (32'(sent) << 4);
                in_sub   = sent[1];
                in_cin   = sent[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== (out_ready || !out_valid))
                $display("FAIL bp_in_ready: got %b expected %b at cycle %0d", in_ready, (out_ready || !out_valid), cyc);
            else passes++;
            if (out_valid && !out_ready) begin
                if (held_set) begin
                    checks++;
                    if ({out_ovf, out_cout, out_sum} !== held)
                        $display("FAIL bp_hold: got %h expected %h at cycle %0d", {out_ovf, out_cout, out_sum}, held, cyc);
                    else passes++;
                end else begin
                    held     = {out_ovf, out_cout, out_sum};
                    held_set = 1'b1;
                end
            end else begin
                held_set = 1'b0;
            end
            if (out_valid && out_ready) begin
                exp_r = (expq.size() > 0) ? expq.pop_front() : 34'h3FFFFFFFF;
                checks++;
                if ({out_ovf, out_cout, out_sum} !== exp_r)
                    $display("FAIL bp_result%0d: got %h expected %h", got, {out_ovf, out_cout, out_sum}, exp_r);
                else passes++;
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_model(in_a, in_b, in_sub, in_cin));
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if ((got != 12) || (sent != 12) || (expq.size() != 0))
            $display("FAIL bp_count: got %0d results of %0d sent, %0d left, expected 12 of 12, 0 left", got, sent, expq.size());
        else passes++;
    endtask

    task automatic test_reset_mid();
        int spurious, lat;
        spurious = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_a = 32'hA5A5A5A5 + 32'(i); in_b = 32'h0000FFFF; in_sub = 1'b0; in_cin = 1'b0;
        end
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (out_sum !== 32'h0) $display("FAIL rstmid_out_sum: got %h expected 00000000", out_sum); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); else passes++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid) spurious++;
        end
        checks++; if (spurious != 0) $display("FAIL rstmid_flushed: got %0d stray results expected 0", spurious); else passes++;
        send_main(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
        checks++; if (lat != 4) $display("FAIL rstmid_latency: got %0d expected 4", lat); else passes++;
        checks++; if (out_sum !== 32'h23456789) $display("FAIL rstmid_sum: got %h expected 23456789", out_sum); else passes++;
        send_main(32'h00000001, 32'h00000002, 1'b1, 1'b0, lat);
        checks++; if ({out_cout, out_sum} !== {1'b0, 32'hFFFFFFFF}) $display("FAIL rstmid_sub: got cout=%b sum=%h expected cout=0 sum=ffffffff", out_cout, out_sum); else passes++;
    endtask

    task automatic test_sweep();
        int lat;
        checks++; if ({r64, r8, r48} !== 3'b111) $display("FAIL sweep_in_ready: got %b expected 111", {r64, r8, r48}); else passes++;

        send_sweep(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
        checks++; if (lat != 4) $display("FAIL w64_latency: got %0d expected 4", lat); else passes++;
        checks++; if (sum64 !== 64'h8000_0000_0000_0000) $display("FAIL w64_sum: got %h expected 8000000000000000", sum64); else passes++;
        checks++; if ({co64, of64} !== 2'b01) $display("FAIL w64_flags: got cout=%b ovf=%b expected cout=0 ovf=1", co64, of64); else passes++;
        send_sweep(0, 64'h0, 64'h1, 1'b1, 1'b0, lat);
        checks++; if ({co64, of64, sum64} !== {2'b00, 64'hFFFF_FFFF_FFFF_FFFF}) $display("FAIL w64_sub: got cout=%b ovf=%b sum=%h expected 0 0 ffffffffffffffff", co64, of64, sum64); else passes++;

        send_sweep(1, 64'h7F, 64'h01, 1'b0, 1'b0, lat);
        checks++; if (lat != 1) $display("FAIL w8_latency: got %0d expected 1", lat); else passes++;
        checks++; if ({co8, of8, sum8} !== {2'b01, 8'h80}) $display("FAIL w8_add: got cout=%b ovf=%b sum=%h expected 0 1 80", co8, of8, sum8); else passes++;
        send_sweep(1, 64'h00, 64'h01, 1'b1, 1'b0, lat);
        checks++; if ({co8, of8, sum8} !== {2'b00, 8'hFF}) $display("FAIL w8_sub: got cout=%b ovf=%b sum=%h expected 0 0 ff", co8, of8, sum8); else passes++;

        send_sweep(2, 64'hFFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
        checks++; if (lat != 12) $display("FAIL w48_latency: got %0d expected 12", lat); else passes++;
        checks++; if ({co48, of48, sum48} !== {2'b10, 48'h0}) $display("FAIL w48_add: got cout=%b ovf=%b sum=%h expected 1 0 000000000000", co48, of48, sum48); else passes++;
        send_sweep(2, 64'h1, 64'h2, 1'b1, 1'b1, lat);
        checks++; if ({co48, of48, sum48} !== {2'b00, 48'hFFFF_FFFF_FFFE}) $display("FAIL w48_sub: got cout=%b ovf=%b sum=%h expected 0 0 fffffffffffe", co48, of48, sum48); else passes++;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b1;
        v64 = 1'b0; a64 = '0; b64 = '0; s64 = 1'b0; c64 = 1'b0; or64 = 1'b1;
        v8  = 1'b0; a8  = '0; b8  = '0; s8  = 1'b0; c8  = 1'b0; or8  = 1'b1;
        v48 = 1'b0; a48 = '0; b48 = '0; s48 = 1'b0; c48 = 1'b0; or48 = 1'b1;

        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_sweep();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
